// File: rtl/gate_truth_table_sequencer.sv
// Sweeps every input vector into an N-input combinational gate, captures its truth table
// and compares it to EXPECTED. Define STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module gate_truth_table_sequencer #(
    parameter int                          N_INPUTS    = 2,
    parameter int                          HOLD_CYCLES = 4,
    parameter logic [(2**N_INPUTS)-1:0]    EXPECTED    = 4'b0111
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        gate_out,
    output logic [N_INPUTS-1:0]         a_drive,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [(2**N_INPUTS)-1:0]    captured,
    output logic [N_INPUTS-1:0]         fail_index
);

    localparam int                  T         = 2**N_INPUTS;
    localparam int                  HC_W      = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HC_W-1:0]     HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] IDX_LAST  = N_INPUTS'(T - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t                 r_state, w_state;
    logic [N_INPUTS-1:0]    r_idx, w_idx;
    logic [HC_W-1:0]        r_hold, w_hold;
    logic [N_INPUTS-1:0]    r_a_drive, w_a_drive;
    logic                   r_busy, w_busy;
    logic                   r_done, w_done;
    logic                   r_pass, w_pass;
    logic [T-1:0]           r_captured, w_captured;
    logic [N_INPUTS-1:0]    r_fail_index, w_fail_index;

    logic [T-1:0]           w_cap_sampled;
    logic                   w_mismatch;
    logic                   w_stop;

    // Scanning from the top down leaves the lowest mismatching index in r.
    function automatic logic [N_INPUTS-1:0] first_mismatch(input logic [T-1:0] cap);
        logic [N_INPUTS-1:0] r;
        r = '0;
        for (int i = T - 1; i >= 0; i--) begin
            if (cap[i] != EXPECTED[i]) begin
                r = N_INPUTS'(i);
            end
        end
        return r;
    endfunction

    always_comb begin
        // captured is cleared at start, so OR-ing in the new bit is a plain write.
        w_cap_sampled = r_captured | (T'(gate_out) << r_idx);
        w_mismatch    = (gate_out != EXPECTED[r_idx]);
`ifdef STOP_ON_FAIL_EN
        w_stop        = w_mismatch || (r_idx == IDX_LAST);
`else
        w_stop        = (r_idx == IDX_LAST);
`endif
    end

    always_comb begin
        w_state      = r_state;
        w_idx        = r_idx;
        w_hold       = r_hold;
        w_a_drive    = r_a_drive;
        w_busy       = r_busy;
        w_done       = r_done;
        w_pass       = r_pass;
        w_captured   = r_captured;
        w_fail_index = r_fail_index;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state      = S_SWEEP;
                    w_idx        = '0;
                    w_hold       = '0;
                    w_a_drive    = '0;
                    w_busy       = 1'b1;
                    w_done       = 1'b0;
                    w_pass       = 1'b0;
                    w_captured   = '0;
                    w_fail_index = '0;
                end
            end

            S_SWEEP: begin
                if (r_hold == HOLD_LAST) begin
                    w_hold     = '0;
                    w_captured = w_cap_sampled;
                    if (w_stop) begin
                        w_state      = S_IDLE;
                        w_idx        = '0;
                        w_a_drive    = '0;
                        w_busy       = 1'b0;
                        w_done       = 1'b1;
                        w_pass       = (w_cap_sampled == EXPECTED);
                        w_fail_index = (w_cap_sampled == EXPECTED) ? '0
                                                                   : first_mismatch(w_cap_sampled);
                    end else begin
                        w_idx     = r_idx + 1'b1;
                        w_a_drive = r_idx + 1'b1;
                    end
                end else begin
                    w_hold = r_hold + 1'b1;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_hold       <= '0;
            r_a_drive    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_captured   <= '0;
            r_fail_index <= '0;
        end else begin
            r_state      <= w_state;
            r_idx        <= w_idx;
            r_hold       <= w_hold;
            r_a_drive    <= w_a_drive;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_pass       <= w_pass;
            r_captured   <= w_captured;
            r_fail_index <= w_fail_index;
        end
    end

    assign a_drive    = r_a_drive;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign captured   = r_captured;
    assign fail_index = r_fail_index;

endmodule
